imc_result_collector: RTL and testbench

- Downstream stage of the IMC instruction decoder. It consumes the sense-amp and ADC strobes the decoder drives (SAEN_CSA1/2, CLK_EN_ADC1/2) together with the analog macro's digitised outputs.
- Tags each sample with its column and buffers it in a result FIFO. Accumulates MAC partial sums.
- Exposes results to the wishbone read side through a pop handshake.

---
 rtl/imc_pkg.sv | 32 +++
 rtl/imc_result_collector_if.sv | 16 +
 rtl/imc_result_collector_fifo.sv | 93 +++++++++
 rtl/imc_result_collector.sv | 168 ++++++++++++++++
 tb/tb_imc_result_collector.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imc_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the IMC result collector.
package imc_pkg;

  localparam int ADC_WIDTH  = 4;
  localparam int COL_W      = 4;
  localparam int SUM_WIDTH  = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 4;
  localparam int ENTRY_W    = 1 + COL_W + SUM_WIDTH;

  localparam logic ENTRY_READ = 1'b0;
  localparam logic ENTRY_MAC  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MAC_ACC = 2'd1,
    ST_MAC_FIN = 2'd2
  } imc_state_e;

  // Accumulate one ADC code, clamping at all-ones instead of wrapping.
  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] acc,
                                                   input logic [ADC_WIDTH-1:0] code);
    logic [SUM_WIDTH:0] sum_s;
    sum_s = {1'b0, acc} + {{(SUM_WIDTH + 1 - ADC_WIDTH){1'b0}}, code};
    if (sum_s[SUM_WIDTH]) begin
      sat_add = {SUM_WIDTH{1'b1}};
    end else begin
      sat_add = sum_s[SUM_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/imc_result_collector_if.sv
// Wishbone-facing read port of the result collector: pop request, data and FIFO status.
interface imc_result_collector_if
  import imc_pkg::*;
();

  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;
  logic               empty;
  logic               full;
  logic [PTR_W:0]     count;

  modport master (output rd_en, input rd_data, rd_valid, empty, full, count);
  modport slave  (input rd_en, output rd_data, rd_valid, empty, full, count);

endinterface

// File: rtl/imc_result_collector_fifo.sv
// Synchronous result FIFO; a pop accepted at one edge presents its data after the following edge.
module imc_result_fifo
  import imc_pkg::*;
#(
  parameter int DATA_W = ENTRY_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AW     = PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count,
  output logic              drop
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic [DATA_W-1:0] pop_data_r;
  logic              pop_pend_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok_s    = pop & ~empty_r;
    push_ok_s   = push & (~full_r | pop_ok_s);
    drop        = push & ~push_ok_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents are meaningless after reset since the pointers restart.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy flags and the two-stage read return path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW + 1){1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      pop_data_r <= {DATA_W{1'b0}};
      pop_pend_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r   <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
        pop_data_r <= mem_r[rd_ptr_r];
      end
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == {(AW + 1){1'b0}});
      full_r     <= (count_nxt_s == (AW + 1)'(DEPTH));
      pop_pend_r <= pop_ok_s;
      rd_valid_r <= pop_pend_r;
      if (pop_pend_r) begin
        rd_data_r <= pop_data_r;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;

endmodule

// File: rtl/imc_result_collector.sv
// Collects decoder-strobed CSA read bits and ADC samples, tags them with the column,
// accumulates MAC partial sums and queues every result for the wishbone read side.
module imc_result_collector
  import imc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   saen_csa1,
  input  logic                   saen_csa2,
  input  logic                   csa1_out,
  input  logic                   csa2_out,
  input  logic                   clk_en_adc1,
  input  logic                   clk_en_adc2,
  input  logic [ADC_WIDTH-1:0]   adc1_code,
  input  logic [ADC_WIDTH-1:0]   adc2_code,
  input  logic [COL_W-1:0]       col_tag,
  input  logic                   mac_last,
  imc_result_collector_if.slave  rd_bus,
  output logic [SUM_WIDTH-1:0]   mac_sum,
  output logic                   mac_done,
  output logic                   overflow,
  output logic                   protocol_err
);

  imc_state_e           state_r;
  imc_state_e           state_nxt_s;
  logic                 saen1_prev_r;
  logic                 saen2_prev_r;
  logic [SUM_WIDTH-1:0] mac_sum_r;
  logic [SUM_WIDTH-1:0] mac_sum_nxt_s;
  logic                 mac_done_r;
  logic                 mac_done_nxt_s;
  logic                 overflow_r;
  logic                 protocol_err_r;
  logic                 err_s;
  logic                 rise1_s;
  logic                 rise2_s;
  logic                 rise_any_s;
  logic                 adc_any_s;
  logic                 adc_both_s;
  logic [ADC_WIDTH-1:0] adc_code_s;
  logic [SUM_WIDTH-1:0] adc_ext_s;
  logic                 read_bit_s;
  logic                 push_s;
  logic [ENTRY_W-1:0]   push_data_s;
  logic                 drop_s;

  // Strobe decode; CSA1 and ADC1 win when both channels fire together.
  always_comb begin
    rise1_s    = saen_csa1 & ~saen1_prev_r;
    rise2_s    = saen_csa2 & ~saen2_prev_r;
    rise_any_s = rise1_s | rise2_s;
    adc_any_s  = clk_en_adc1 | clk_en_adc2;
    adc_both_s = clk_en_adc1 & clk_en_adc2;
    if (clk_en_adc1) begin
      adc_code_s = adc1_code;
    end else begin
      adc_code_s = adc2_code;
    end
    if (rise1_s) begin
      read_bit_s = csa1_out;
    end else begin
      read_bit_s = csa2_out;
    end
    adc_ext_s = {{(SUM_WIDTH - ADC_WIDTH){1'b0}}, adc_code_s};
  end

  // Next-state, push and error decisions for the collector FSM.
  always_comb begin
    state_nxt_s    = state_r;
    mac_sum_nxt_s  = mac_sum_r;
    mac_done_nxt_s = 1'b0;
    push_s         = 1'b0;
    push_data_s    = {ENTRY_W{1'b0}};
    err_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (adc_any_s) begin
          push_s        = 1'b1;
          push_data_s   = {ENTRY_MAC, col_tag, adc_ext_s};
          mac_sum_nxt_s = adc_ext_s;
          err_s         = adc_both_s | rise_any_s;
          if (mac_last) begin
            state_nxt_s    = ST_MAC_FIN;
            mac_done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_MAC_ACC;
          end
        end else if (rise_any_s) begin
          push_s      = 1'b1;
          push_data_s = {ENTRY_READ, col_tag, {(SUM_WIDTH - 1){1'b0}}, read_bit_s};
          err_s       = rise1_s & rise2_s;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_MAC_ACC: begin
        if (adc_any_s) begin
          push_s        = 1'b1;
          push_data_s   = {ENTRY_MAC, col_tag, adc_ext_s};
          mac_sum_nxt_s = sat_add(mac_sum_r, adc_code_s);
          err_s         = adc_both_s | rise_any_s;
          if (mac_last) begin
            state_nxt_s    = ST_MAC_FIN;
            mac_done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_MAC_ACC;
          end
        end else begin
          err_s = rise_any_s;
        end
      end
      ST_MAC_FIN: begin
        // Strobes landing on the completion cycle have nowhere legal to go.
        state_nxt_s = ST_IDLE;
        err_s       = adc_any_s | rise_any_s;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, accumulator, strobe history and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      saen1_prev_r   <= 1'b0;
      saen2_prev_r   <= 1'b0;
      mac_sum_r      <= {SUM_WIDTH{1'b0}};
      mac_done_r     <= 1'b0;
      overflow_r     <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      saen1_prev_r   <= saen_csa1;
      saen2_prev_r   <= saen_csa2;
      mac_sum_r      <= mac_sum_nxt_s;
      mac_done_r     <= mac_done_nxt_s;
      overflow_r     <= overflow_r | drop_s;
      protocol_err_r <= protocol_err_r | err_s;
    end
  end

  imc_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .AW     (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (rd_bus.rd_en),
    .rd_data   (rd_bus.rd_data),
    .rd_valid  (rd_bus.rd_valid),
    .empty     (rd_bus.empty),
    .full      (rd_bus.full),
    .count     (rd_bus.count),
    .drop      (drop_s)
  );

  assign mac_sum      = mac_sum_r;
  assign mac_done     = mac_done_r;
  assign overflow     = overflow_r;
  assign protocol_err = protocol_err_r;

endmodule

// File: tb/tb_imc_result_collector.sv
// Directed self-checking bench for imc_result_collector; inputs change and outputs are sampled on negedge.
module tb_imc_result_collector;
  import imc_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 saen_csa1, saen_csa2, csa1_out, csa2_out;
  logic                 clk_en_adc1, clk_en_adc2;
  logic [ADC_WIDTH-1:0] adc1_code, adc2_code;
  logic [COL_W-1:0]     col_tag;
  logic                 mac_last;
  logic [SUM_WIDTH-1:0] mac_sum;
  logic                 mac_done, overflow, protocol_err;

  int assert_cnt;
  int fail_cnt;
  logic [ENTRY_W-1:0] exp_q [$];

  imc_result_collector_if rd_bus ();

  imc_result_collector dut (
    .clk          (clk),
    .rst          (rst),
    .saen_csa1    (saen_csa1),
    .saen_csa2    (saen_csa2),
    .csa1_out     (csa1_out),
    .csa2_out     (csa2_out),
    .clk_en_adc1  (clk_en_adc1),
    .clk_en_adc2  (clk_en_adc2),
    .adc1_code    (adc1_code),
    .adc2_code    (adc2_code),
    .col_tag      (col_tag),
    .mac_last     (mac_last),
    .rd_bus       (rd_bus),
    .mac_sum      (mac_sum),
    .mac_done     (mac_done),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " empty"}, 32'(rd_bus.empty), 32'd1);
    check_eq({tag, " full"}, 32'(rd_bus.full), 32'd0);
    check_eq({tag, " count"}, 32'(rd_bus.count), 32'd0);
    check_eq({tag, " rd_valid"}, 32'(rd_bus.rd_valid), 32'd0);
    check_eq({tag, " rd_data"}, 32'(rd_bus.rd_data), 32'd0);
    check_eq({tag, " mac_sum"}, 32'(mac_sum), 32'd0);
    check_eq({tag, " mac_done"}, 32'(mac_done), 32'd0);
    check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
    check_eq({tag, " protocol_err"}, 32'(protocol_err), 32'd0);
  endtask

  // Pop n entries back to back and compare each returned word against exp_q.
  task automatic drain(input string tag, input int n);
    for (int i = 0; i <= n; i++) begin
      rd_bus.rd_en = (i < n);
      step();
      if (i >= 1) begin
        check_eq({tag, " rd_valid"}, 32'(rd_bus.rd_valid), 32'd1);
        check_eq({tag, " rd_data"}, 32'(rd_bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
    rd_bus.rd_en = 1'b0;
    step();
    check_eq({tag, " rd_valid drop"}, 32'(rd_bus.rd_valid), 32'd0);
    check_eq({tag, " empty"}, 32'(rd_bus.empty), 32'd1);
  endtask

  task automatic adc_sample(input logic [3:0] code, input logic [3:0] col, input logic last);
    clk_en_adc1 = 1'b1;
    adc1_code   = code;
    col_tag     = col;
    mac_last    = last;
    step();
  endtask

  task automatic idle_inputs();
    saen_csa1 = 1'b0; saen_csa2 = 1'b0; csa1_out = 1'b0; csa2_out = 1'b0;
    clk_en_adc1 = 1'b0; clk_en_adc2 = 1'b0; adc1_code = 4'd0; adc2_code = 4'd0;
    col_tag = 4'd0; mac_last = 1'b0; rd_bus.rd_en = 1'b0;
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst = 1'b0;
    idle_inputs();
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Read capture: SAEN1 held high three cycles yields exactly one entry.
    saen_csa1 = 1'b1; csa1_out = 1'b1; col_tag = 4'd3;
    step(); step(); step();
    check_eq("read single push", 32'(rd_bus.count), 32'd1);
    saen_csa1 = 1'b0; csa1_out = 1'b0;
    step();
    rd_bus.rd_en = 1'b1;
    step();
    check_eq("read rd_valid latency", 32'(rd_bus.rd_valid), 32'd0);
    check_eq("read empty after pop", 32'(rd_bus.empty), 32'd1);
    rd_bus.rd_en = 1'b0;
    step();
    check_eq("read rd_valid", 32'(rd_bus.rd_valid), 32'd1);
    check_eq("read rd_data", 32'(rd_bus.rd_data), 32'h0_3001);
    step();
    check_eq("read rd_valid one cycle", 32'(rd_bus.rd_valid), 32'd0);
    check_eq("read rd_data held", 32'(rd_bus.rd_data), 32'h0_3001);

    // MAC accumulate: 5+7+2+9.
    adc_sample(4'd5, 4'd0, 1'b0);
    check_eq("mac sum1", 32'(mac_sum), 32'd5);
    adc_sample(4'd7, 4'd1, 1'b0);
    check_eq("mac sum2", 32'(mac_sum), 32'd12);
    adc_sample(4'd2, 4'd2, 1'b0);
    check_eq("mac sum3", 32'(mac_sum), 32'd14);
    check_eq("mac done early", 32'(mac_done), 32'd0);
    adc_sample(4'd9, 4'd3, 1'b1);
    check_eq("mac sum final", 32'(mac_sum), 32'd23);
    check_eq("mac done pulse", 32'(mac_done), 32'd1);
    clk_en_adc1 = 1'b0; mac_last = 1'b0;
    step();
    check_eq("mac done clears", 32'(mac_done), 32'd0);
    check_eq("mac sum held", 32'(mac_sum), 32'd23);
    check_eq("mac count", 32'(rd_bus.count), 32'd4);
    exp_q = '{17'h1_0005, 17'h1_1007, 17'h1_2002, 17'h1_3009};
    drain("mac drain", 4);
    // Back in IDLE, a SAEN2 rise is a legal read.
    saen_csa2 = 1'b1; csa2_out = 1'b0; col_tag = 4'd9;
    step();
    saen_csa2 = 1'b0;
    check_eq("idle read after mac", 32'(rd_bus.count), 32'd1);
    check_eq("idle read no err", 32'(protocol_err), 32'd0);
    exp_q = '{17'h0_9000};
    drain("csa2 drain", 1);

    // Full boundary: 16 entries, then simultaneous push and pop.
    for (int i = 0; i < 16; i++) begin
      adc_sample(4'(15 - i), 4'(i), (i == 15));
    end
    check_eq("fill full", 32'(rd_bus.full), 32'd1);
    check_eq("fill count", 32'(rd_bus.count), 32'd16);
    check_eq("fill sum", 32'(mac_sum), 32'd120);
    clk_en_adc1 = 1'b0; mac_last = 1'b0;
    step();
    saen_csa1 = 1'b1; csa1_out = 1'b1; col_tag = 4'd5; rd_bus.rd_en = 1'b1;
    step();
    saen_csa1 = 1'b0; rd_bus.rd_en = 1'b0;
    check_eq("full push+pop count", 32'(rd_bus.count), 32'd16);
    check_eq("full push+pop overflow", 32'(overflow), 32'd0);
    step();
    check_eq("full pop oldest", 32'(rd_bus.rd_data), 32'h1_000F);
    exp_q.delete();
    for (int k = 1; k < 16; k++) begin
      exp_q.push_back({1'b1, 4'(k), 8'd0, 4'(15 - k)});
    end
    exp_q.push_back(17'h0_5001);
    drain("full drain", 16);

    // Protocol error: both ADCs, then a SAEN rise inside MAC_ACC.
    clk_en_adc1 = 1'b1; clk_en_adc2 = 1'b1; adc1_code = 4'd4; adc2_code = 4'd6; col_tag = 4'd2;
    step();
    clk_en_adc1 = 1'b0; clk_en_adc2 = 1'b0;
    check_eq("dual adc sum", 32'(mac_sum), 32'd4);
    check_eq("dual adc err", 32'(protocol_err), 32'd1);
    saen_csa1 = 1'b1; csa1_out = 1'b1;
    step();
    saen_csa1 = 1'b0;
    check_eq("saen in mac ignored", 32'(rd_bus.count), 32'd1);
    check_eq("saen in mac err", 32'(protocol_err), 32'd1);
    adc_sample(4'd3, 4'd2, 1'b1);
    check_eq("proto mac sum", 32'(mac_sum), 32'd7);
    check_eq("proto mac done", 32'(mac_done), 32'd1);
    clk_en_adc1 = 1'b0; mac_last = 1'b0;
    step();
    exp_q = '{17'h1_2004, 17'h1_2003};
    drain("proto drain", 2);

    // Saturation and overflow.
    for (int i = 0; i < 300; i++) begin
      adc_sample(4'd15, 4'd0, (i == 299));
      if (i == 15) begin
        check_eq("sat count16", 32'(rd_bus.count), 32'd16);
        check_eq("sat no overflow yet", 32'(overflow), 32'd0);
      end
      if (i == 16) begin
        check_eq("sat overflow set", 32'(overflow), 32'd1);
      end
    end
    clk_en_adc1 = 1'b0; mac_last = 1'b0;
    check_eq("sat mac_sum", 32'(mac_sum), 32'd4095);
    check_eq("sat count", 32'(rd_bus.count), 32'd16);
    check_eq("sat full", 32'(rd_bus.full), 32'd1);
    check_eq("sat overflow sticky", 32'(overflow), 32'd1);
    step();

    // Reset mid-MAC with five entries queued.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      adc_sample(4'd2, 4'(i), 1'b0);
    end
    check_eq("pre-reset count", 32'(rd_bus.count), 32'd5);
    check_eq("pre-reset sum", 32'(mac_sum), 32'd10);
    rst = 1'b0;
    clk_en_adc1 = 1'b0;
    #1;
    check_reset_outputs("async reset");
    step();
    rst = 1'b1;
    step();
    check_eq("post-reset empty", 32'(rd_bus.empty), 32'd1);
    check_eq("post-reset sum", 32'(mac_sum), 32'd0);
    saen_csa1 = 1'b1; csa1_out = 1'b0; col_tag = 4'd7;
    step();
    saen_csa1 = 1'b0;
    check_eq("post-reset idle read", 32'(rd_bus.count), 32'd1);
    check_eq("post-reset no err", 32'(protocol_err), 32'd0);
    exp_q = '{17'h0_7000};
    drain("post-reset drain", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
